// File: rtl/seq_signed_multiplier_pkg.sv
// Shared definitions for the sequential signed multiplier: FSM state encoding
// and the iteration-counter width helper.
package seq_mult_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bits needed to count 0..w-1; never below one bit.
    function automatic int cnt_width(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < w) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/carry_look_adder.sv
// Unsigned adder built from generate/propagate terms; carry out is discarded,
// callers widen the operands when they need it.
module carry_look_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Carry chain from the generate/propagate terms, then the sum bits.
    always_comb begin
        c_s    = {WIDTH{1'b0}};
        c_s[0] = cin;
        for (int i = 1; i < WIDTH; i++) begin
            c_s[i] = g_s[i-1] | (p_s[i-1] & c_s[i-1]);
        end
        sum = p_s ^ c_s;
    end

endmodule

// File: rtl/complimenter_2.sv
// Two's-complement negator, wrapping modulo 2^WIDTH (so 0 maps to 0).
module complimenter_2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    carry_look_adder #(.WIDTH(WIDTH)) u_inc (
        .a   (~in),
        .b   ({WIDTH{1'b0}}),
        .cin (1'b1),
        .sum (out)
    );

endmodule

// File: rtl/seq_signed_multiplier_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator/multiplier-quotient pair
// and the final sign fix-up into the registered product.
module shift_add_datapath #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   neg_a_s;
    logic [WIDTH-1:0]   neg_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   mag_a_r;
    logic               neg_r;
    logic [WIDTH:0]     acc_r;
    logic [WIDTH-1:0]   mq_r;
    logic [WIDTH:0]     addend_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] raw_s;
    logic [2*WIDTH-1:0] raw_neg_s;
    logic [2*WIDTH-1:0] product_r;

    complimenter_2 #(.WIDTH(WIDTH)) u_comp_a (.in(a), .out(neg_a_s));
    complimenter_2 #(.WIDTH(WIDTH)) u_comp_b (.in(b), .out(neg_b_s));

    // Magnitudes are unsigned, so the most negative operand maps cleanly.
    assign mag_a_s = a[WIDTH-1] ? neg_a_s : a;
    assign mag_b_s = b[WIDTH-1] ? neg_b_s : b;

    assign addend_s = mq_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}};

    carry_look_adder #(.WIDTH(WIDTH+1)) u_add (
        .a   (acc_r),
        .b   (addend_s),
        .cin (1'b0),
        .sum (sum_s)
    );

    assign raw_s = {acc_r[WIDTH-1:0], mq_r};

    complimenter_2 #(.WIDTH(2*WIDTH)) u_comp_p (.in(raw_s), .out(raw_neg_s));

    // Operand capture on load, one add-then-shift per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_a_r <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            acc_r   <= {(WIDTH+1){1'b0}};
            mq_r    <= {WIDTH{1'b0}};
        end else if (load) begin
            mag_a_r <= mag_a_s;
            neg_r   <= a[WIDTH-1] ^ b[WIDTH-1];
            acc_r   <= {(WIDTH+1){1'b0}};
            mq_r    <= mag_b_s;
        end else if (step) begin
            acc_r   <= {1'b0, sum_s[WIDTH:1]};
            mq_r    <= {sum_s[0], mq_r[WIDTH-1:1]};
        end else begin
            mag_a_r <= mag_a_r;
            neg_r   <= neg_r;
            acc_r   <= acc_r;
            mq_r    <= mq_r;
        end
    end

    // Product register: written only by the sign fix-up, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            product_r <= {(2*WIDTH){1'b0}};
        end else if (fix) begin
            product_r <= neg_r ? raw_neg_s : raw_s;
        end else begin
            product_r <= product_r;
        end
    end

    assign product = product_r;

endmodule

// File: rtl/seq_signed_multiplier.sv
// Sequential signed multiplier: start/busy/done FSM and iteration counter
// driving the shared shift-add datapath.
module seq_signed_multiplier
    import seq_mult_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] cnt_r;
    logic          load_s;
    logic          step_s;
    logic          fix_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = SIGN;
                end else begin
                    state_next_s = CALC;
                end
            end
            SIGN:    state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output and strobe decode from the state register.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        fix_s  = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (state_r)
            IDLE: begin
                busy   = 1'b0;
                load_s = start;
            end
            CALC:    step_s = 1'b1;
            SIGN:    fix_s  = 1'b1;
            DONE:    done   = 1'b1;
            default: busy   = 1'b0;
        endcase
    end

    // Iteration counter: cleared on load, advanced once per CALC edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (step_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    shift_add_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .step    (step_s),
        .fix     (fix_s),
        .a       (a),
        .b       (b),
        .product (product)
    );

endmodule
